// File: rtl/pipe_stage_if.sv
// pipe_stage_if: handshake bundle between an upstream producer, the pipe_stage and its downstream consumer.
//   slave  modport (stage side):  in_valid/in_data/in_ctrl/hazard_stall_n/flush/out_ready in,
//                                 in_ready/out_valid/out_data/out_ctrl/stall_cnt/err out
//   master modport (driver side): the mirror image
interface pipe_stage_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              hazard_stall_n;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [15:0]       stall_cnt;
    logic              err;

    modport slave (
        input  in_valid, in_data, in_ctrl, hazard_stall_n, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, stall_cnt, err
    );

    modport master (
        output in_valid, in_data, in_ctrl, hazard_stall_n, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, stall_cnt, err
    );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: one pipeline register stage with optional two-entry skid buffer, flush, hazard stall and stall counter.
//   clk, rst (async, active-high) plain ports; all handshake/data signals via pipe_stage_if.slave bus.
module pipe_stage #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input logic         clk,
    input logic         rst,
    pipe_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [15:0]       r_stall_cnt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_pop;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_skid_to_main;

    assign w_out_valid = r_state != EMPTY;
    // With a skid entry, readiness depends only on local state; without it,
    // a full stage can still take a new entry when the held one leaves this cycle.
    assign w_in_ready  = ~rst & bus.hazard_stall_n &
                         ((SKID != 0) ? (r_state != TWO) : ((r_state == EMPTY) | bus.out_ready));
    assign w_accept    = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next      = w_accept ? ONE : EMPTY;
                w_load_main = w_accept;
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept && SKID != 0) begin
                    w_next      = TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_next = EMPTY;
                end
            end
            TWO: begin
                w_next         = w_pop ? ONE : TWO;
                w_skid_to_main = w_pop;
            end
            default: w_next = EMPTY;
        endcase
        if (bus.flush) w_next = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_ctrl      <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main) begin
                r_data <= bus.in_data;
                r_ctrl <= bus.in_ctrl;
            end else if (w_skid_to_main) begin
                r_data <= r_skid_data;
                r_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.in_data;
                r_skid_ctrl <= bus.in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_stall_cnt <= '0;
        else if (w_out_valid & ~bus.out_ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data;
    // Control bits must never look live on a bubble.
    assign bus.out_ctrl  = w_out_valid ? r_ctrl : '0;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.err       = $isunknown({bus.in_valid, bus.out_ready, bus.hazard_stall_n, bus.flush}) |
                           (bus.in_valid & $isunknown({bus.in_data, bus.in_ctrl}));
endmodule
